// File: rtl/fll_clkdiv_bank.sv
// rtl/fll_clkdiv_bank.sv - bank of NB_FLL programmable REFCLK/(2*D) clock dividers with CFG access and lock flags
//
// Optional build macro: FLL_STATUS_REG_EN (status register with LOCK readback and soft resync at address NB_FLL)
//
// Ports:
//   REFCLK  in   reference clock, all state on its rising edge
//   RSTB    in   asynchronous active-low reset
//   OUTCLK  out  [NB_FLL] divided clocks, registered
//   LOCK    out  [NB_FLL] per-channel lock flag
//   CFGREQ  in   config request (4-phase)
//   CFGACK  out  config acknowledge, one-cycle pulse
//   CFGAD   in   [CFG_ADDR_WIDTH] register address
//   CFGD    in   [CFG_DATA_WIDTH] write data
//   CFGQ    out  [CFG_DATA_WIDTH] read data, valid while CFGACK=1
//   CFGWEB  in   write enable, active low
//   PWD     in   synchronous power down, active high
module fll_clkdiv_bank #(
    parameter int NB_FLL         = 4,
    parameter int CFG_ADDR_WIDTH = 4,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int DIV_WIDTH      = 8,
    parameter int DIV_RESET      = 1,
    parameter int LOCK_CYCLES    = 16
) (
    input  logic                      REFCLK,
    input  logic                      RSTB,
    output logic [NB_FLL-1:0]         OUTCLK,
    output logic [NB_FLL-1:0]         LOCK,
    input  logic                      CFGREQ,
    output logic                      CFGACK,
    input  logic [CFG_ADDR_WIDTH-1:0] CFGAD,
    input  logic [CFG_DATA_WIDTH-1:0] CFGD,
    output logic [CFG_DATA_WIDTH-1:0] CFGQ,
    input  logic                      CFGWEB,
    input  logic                      PWD
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCW-1:0]       LC_LAST = LCW'(LOCK_CYCLES - 1);
    localparam logic [DIV_WIDTH-1:0] D_RST   = DIV_WIDTH'(DIV_RESET);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_ACK,
        S_WAITLO
    } cfg_state_t;

    cfg_state_t state_q, state_d;

    logic [CFG_ADDR_WIDTH-1:0] cap_ad_q;
    logic [DIV_WIDTH-1:0]      cap_d_q;
    logic                      cap_web_q;
    logic                      ack_d;
    logic [CFG_DATA_WIDTH-1:0] q_d;
    logic [CFG_DATA_WIDTH-1:0] rdata;

    logic [DIV_WIDTH-1:0] shadow_q [NB_FLL];
    logic [DIV_WIDTH-1:0] act_q    [NB_FLL];
    logic [DIV_WIDTH-1:0] cnt_q    [NB_FLL];
    logic [LCW-1:0]       lcnt_q   [NB_FLL];
    logic [DIV_WIDTH-1:0] sh_nxt   [NB_FLL];

    logic [NB_FLL-1:0] wr;
    logic [NB_FLL-1:0] clr;
    logic [NB_FLL-1:0] boundary;
    logic [NB_FLL-1:0] apply;
    logic              resync;

    // Only the divide field of the write data is stored.
    generate
        if (CFG_DATA_WIDTH > DIV_WIDTH) begin : g_cfgd_hi
            logic unused_cfgd_hi;
            assign unused_cfgd_hi = ^CFGD[CFG_DATA_WIDTH-1:DIV_WIDTH];
        end
    endgenerate

`ifdef FLL_STATUS_REG_EN
    localparam logic [CFG_ADDR_WIDTH-1:0] STAT_ADDR = CFG_ADDR_WIDTH'(NB_FLL);
    // Soft resync fires on the same edge a divide write would land.
    assign resync = (state_q == S_ACK) && !cap_web_q && (cap_ad_q == STAT_ADDR) && cap_d_q[0];
`else
    assign resync = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NB_FLL; i++) begin
            if (cap_ad_q == CFG_ADDR_WIDTH'(i)) rdata = CFG_DATA_WIDTH'(shadow_q[i]);
        end
`ifdef FLL_STATUS_REG_EN
        if (cap_ad_q == STAT_ADDR) rdata = CFG_DATA_WIDTH'(LOCK);
`endif
    end

    // CFG FSM. LATCH gives the registered ACK/Q their one-cycle delay so the
    // ACK cycle sits between the second and third edge after REQ.
    always_ff @(posedge REFCLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q   <= S_IDLE;
            CFGACK    <= 1'b0;
            CFGQ      <= '0;
            cap_ad_q  <= '0;
            cap_d_q   <= '0;
            cap_web_q <= 1'b1;
        end else begin
            state_q <= state_d;
            CFGACK  <= ack_d;
            CFGQ    <= q_d;
            if (state_q == S_IDLE && CFGREQ) begin
                cap_ad_q  <= CFGAD;
                cap_d_q   <= CFGD[DIV_WIDTH-1:0];
                cap_web_q <= CFGWEB;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        q_d     = '0;
        case (state_q)
            S_IDLE:   if (CFGREQ) state_d = S_LATCH;
            S_LATCH: begin
                state_d = S_ACK;
                ack_d   = 1'b1;
                if (cap_web_q) q_d = rdata;
            end
            S_ACK:    state_d = S_WAITLO;
            S_WAITLO: if (!CFGREQ) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Per-channel control. sh_nxt folds in a write landing this edge so a
    // write coinciding with a period boundary is applied immediately.
    always_comb begin
        wr       = '0;
        clr      = '0;
        boundary = '0;
        apply    = '0;
        for (int i = 0; i < NB_FLL; i++) begin
            sh_nxt[i] = shadow_q[i];
            if (!cap_web_q && cap_ad_q == CFG_ADDR_WIDTH'(i)) begin
                wr[i]  = (state_q == S_ACK);
                clr[i] = (state_q == S_LATCH) && (cap_d_q != shadow_q[i]) && (cap_d_q != act_q[i]);
            end
            if (wr[i]) sh_nxt[i] = cap_d_q;
            boundary[i] = (act_q[i] != '0) && OUTCLK[i] && (cnt_q[i] == act_q[i] - 1'b1);
            apply[i]    = PWD || resync ||
                          ((sh_nxt[i] != act_q[i]) && ((act_q[i] == '0) || boundary[i]));
        end
    end

    always_ff @(posedge REFCLK or negedge RSTB) begin
        if (!RSTB) begin
            OUTCLK <= '0;
            LOCK   <= '0;
            for (int i = 0; i < NB_FLL; i++) begin
                shadow_q[i] <= D_RST;
                act_q[i]    <= D_RST;
                cnt_q[i]    <= '0;
                lcnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NB_FLL; i++) begin
                shadow_q[i] <= sh_nxt[i];
                if (apply[i]) begin
                    // New ratio starts on a fresh low phase; lock restarts.
                    act_q[i]  <= sh_nxt[i];
                    cnt_q[i]  <= '0;
                    OUTCLK[i] <= 1'b0;
                    lcnt_q[i] <= '0;
                    LOCK[i]   <= 1'b0;
                end else begin
                    if (act_q[i] == '0) begin
                        cnt_q[i]  <= '0;
                        OUTCLK[i] <= 1'b0;
                    end else if (cnt_q[i] == act_q[i] - 1'b1) begin
                        cnt_q[i]  <= '0;
                        OUTCLK[i] <= ~OUTCLK[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                    // Lock only counts while no new ratio is pending.
                    if (clr[i]) begin
                        LOCK[i]   <= 1'b0;
                        lcnt_q[i] <= '0;
                    end else if (act_q[i] != '0 && !LOCK[i] && sh_nxt[i] == act_q[i]) begin
                        if (lcnt_q[i] == LC_LAST) LOCK[i] <= 1'b1;
                        else                      lcnt_q[i] <= lcnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fll_clkdiv_bank.sv
// tb/tb_fll_clkdiv_bank.sv - self-checking bench for fll_clkdiv_bank
module tb_fll_clkdiv_bank;

`ifdef FLL_STATUS_REG_EN
    localparam logic [31:0] STAT_EXP = 32'hF;
`else
    localparam logic [31:0] STAT_EXP = 32'h0;
`endif

    logic        REFCLK, RSTB, CFGREQ, CFGACK, CFGWEB, PWD;
    logic [3:0]  OUTCLK, LOCK, CFGAD;
    logic [31:0] CFGD, CFGQ;

    int n_run  = 0;
    int n_fail = 0;

    logic [3:0] so [4];
    logic [3:0] sl [4];

    typedef struct {
        logic        web;
        logic [3:0]  ad;
        logic [31:0] d;
        logic [31:0] q;
        logic [3:0]  lk;
    } vec_t;

    vec_t tbl [11];

    fll_clkdiv_bank dut (
        .REFCLK(REFCLK), .RSTB(RSTB), .OUTCLK(OUTCLK), .LOCK(LOCK),
        .CFGREQ(CFGREQ), .CFGACK(CFGACK), .CFGAD(CFGAD), .CFGD(CFGD),
        .CFGQ(CFGQ), .CFGWEB(CFGWEB), .PWD(PWD)
    );

    initial REFCLK = 1'b0;
    always #5 REFCLK = ~REFCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge REFCLK);
        #1;
    endtask

    // Full 4-phase transfer; ends with the FSM back in IDLE.
    task automatic xfer(input logic web, input logic [3:0] ad, input logic [31:0] d,
                        output logic [31:0] q, output logic ok);
        logic a0, a1, a2;
        CFGREQ = 1'b1; CFGAD = ad; CFGD = d; CFGWEB = web;
        step; a0 = CFGACK; so[0] = OUTCLK; sl[0] = LOCK;
        step; a1 = CFGACK; q = CFGQ; so[1] = OUTCLK; sl[1] = LOCK;
        CFGREQ = 1'b0;
        step; a2 = CFGACK; so[2] = OUTCLK; sl[2] = LOCK;
        step; so[3] = OUTCLK; sl[3] = LOCK;
        ok = !a0 && a1 && !a2;
    endtask

    initial begin
        logic [31:0] q;
        logic        ok;
        int          j, err, acks;
        logic [3:0]  ev;

        RSTB = 1'b0; CFGREQ = 1'b0; CFGAD = '0; CFGD = '0; CFGWEB = 1'b1; PWD = 1'b0;

        tbl[0]  = '{1'b1, 4'd2,  32'd0,   32'd3,   4'hF};
        tbl[1]  = '{1'b1, 4'd0,  32'd0,   32'd1,   4'hF};
        tbl[2]  = '{1'b1, 4'd1,  32'd0,   32'd1,   4'hF};
        tbl[3]  = '{1'b1, 4'd3,  32'd0,   32'd1,   4'hF};
        tbl[4]  = '{1'b0, 4'd1,  32'd1,   32'd0,   4'hF};
        tbl[5]  = '{1'b1, 4'd5,  32'd0,   32'd0,   4'hF};
        tbl[6]  = '{1'b0, 4'd7,  32'hFF,  32'd0,   4'hF};
        tbl[7]  = '{1'b1, 4'd7,  32'd0,   32'd0,   4'hF};
        tbl[8]  = '{1'b0, 4'd4,  32'd2,   32'd0,   4'hF};
        tbl[9]  = '{1'b1, 4'd4,  32'd0,   STAT_EXP, 4'hF};
        tbl[10] = '{1'b1, 4'd15, 32'd0,   32'd0,   4'hF};

        // Reset state
        #12;
        check("rst_outclk", {28'd0, OUTCLK}, 32'h0);
        check("rst_lock",   {28'd0, LOCK},   32'h0);
        check("rst_ack",    {31'd0, CFGACK}, 32'h0);
        check("rst_q",      CFGQ,            32'h0);
        @(posedge REFCLK); #1; RSTB = 1'b1;

        // DIV_RESET=1: toggle every edge, LOCK at the 16th edge
        for (int n = 1; n <= 17; n++) begin
            step;
            err = 0;
            if (OUTCLK !== ((n % 2 == 1) ? 4'hF : 4'h0)) err++;
            if (LOCK !== ((n >= 16) ? 4'hF : 4'h0)) err++;
            check("post_reset_cycle", err, 0);
        end

        // Write ch2 D=3
        xfer(1'b0, 4'd2, 32'd3, q, ok);
        check("wr2_ack", ok, 1);
        check("wr2_q", q, 0);
        check("wr2_lock_drop", {28'd0, sl[1]}, 32'hB);
        if (!so[1][2]) check("wr2_pre_toggle", so[2][2], 1);
        j = so[1][2] ? 1 : 0;
        check("wr2_first", so[3][2], 0);
        err = 0;
        for (int n = 0; n < 30; n++) begin
            step; j++;
            if (OUTCLK[2] !== ((j / 3) % 2 == 1)) err++;
            if (LOCK[2] !== (j >= 16)) err++;
            if (j == 15 || j == 16) check("ch2_lock_edge", LOCK[2], (j == 16));
        end
        check("ch2_pattern", err, 0);

        // Register map table
        for (int t = 0; t < 11; t++) begin
            xfer(tbl[t].web, tbl[t].ad, tbl[t].d, q, ok);
            check($sformatf("tbl%0d_ack", t), ok, 1);
            check($sformatf("tbl%0d_q", t), q, tbl[t].q);
            check($sformatf("tbl%0d_lock", t), {28'd0, LOCK}, {28'd0, tbl[t].lk});
        end

        // Request held high for 10 cycles: one ACK, Q only during ACK
        CFGREQ = 1'b1; CFGAD = 4'd2; CFGWEB = 1'b1;
        acks = 0; err = 0;
        for (int n = 0; n < 10; n++) begin
            step;
            if (CFGACK) begin acks++; if (CFGQ !== 32'h3) err++; end
            else if (CFGQ !== 32'h0) err++;
        end
        CFGREQ = 1'b0;
        step;
        check("hold_ack_count", acks, 1);
        check("hold_q", err, 0);

        // ch0 D=0 then D=255
        xfer(1'b0, 4'd0, 32'd0, q, ok);
        check("wr0_ack", ok, 1);
        check("wr0_lock_drop", sl[1][0], 0);
        err = 0;
        for (int n = 0; n < 20; n++) begin
            step;
            if (OUTCLK[0] !== 1'b0 || LOCK[0] !== 1'b0) err++;
        end
        check("ch0_off", err, 0);
        xfer(1'b0, 4'd0, 32'd255, q, ok);
        check("wr255_ack", ok, 1);
        check("wr255_j0", so[2][0], 0);
        check("wr255_j1", so[3][0], 0);
        j = 1; err = 0;
        for (int n = 0; n < 600; n++) begin
            step; j++;
            if (OUTCLK[0] !== ((j / 255) % 2 == 1)) err++;
            if (j == 254 || j == 255 || j == 509 || j == 510)
                check($sformatf("ch0_255_edge_j%0d", j), OUTCLK[0], ((j / 255) % 2 == 1));
            if (j == 15 || j == 16) check("ch0_lock_edge", LOCK[0], (j == 16));
        end
        check("ch0_255_pattern", err, 0);

        // Power down 20 cycles with a write of ch1 D=5
        PWD = 1'b1;
        step;
        check("pwd_outclk", {28'd0, OUTCLK}, 0);
        check("pwd_lock",   {28'd0, LOCK},   0);
        xfer(1'b0, 4'd1, 32'd5, q, ok);
        check("pwd_wr_ack", ok, 1);
        err = 0;
        for (int n = 0; n < 4; n++) if (so[n] !== 4'h0 || sl[n] !== 4'h0) err++;
        for (int n = 0; n < 15; n++) begin
            step;
            if (OUTCLK !== 4'h0 || LOCK !== 4'h0) err++;
        end
        check("pwd_hold", err, 0);
        PWD = 1'b0;
        j = 0; err = 0;
        for (int n = 0; n < 40; n++) begin
            step; j++;
            ev = {(j % 2 == 1), ((j / 3) % 2 == 1), ((j / 5) % 2 == 1), 1'b0};
            if (OUTCLK !== ev) err++;
            if (LOCK !== ((j >= 16) ? 4'hF : 4'h0)) err++;
            if (j == 15 || j == 16) check("pwd_lock_edge", {28'd0, LOCK}, (j == 16) ? 32'hF : 32'h0);
        end
        check("pwd_release_pattern", err, 0);

        // Status register and soft resync
        xfer(1'b1, 4'd4, 32'd0, q, ok);
        check("stat_read", q, STAT_EXP);
        xfer(1'b0, 4'd4, 32'd1, q, ok);
        check("stat_wr_ack", ok, 1);
`ifdef FLL_STATUS_REG_EN
        check("resync_lock", {28'd0, sl[2]}, 32'h0);
`else
        check("resync_none", {28'd0, sl[2]}, 32'hF);
`endif

        // Reset asserted mid-ACK
        CFGREQ = 1'b1; CFGAD = 4'd1; CFGWEB = 1'b1;
        step;
        step;
        check("midack_ack", CFGACK, 1);
        check("midack_q", CFGQ, 32'h5);
        #2 RSTB = 1'b0;
        #1;
        check("midrst_ack",    CFGACK, 0);
        check("midrst_q",      CFGQ,   0);
        check("midrst_outclk", {28'd0, OUTCLK}, 0);
        check("midrst_lock",   {28'd0, LOCK},   0);
        CFGREQ = 1'b0;
        @(posedge REFCLK); #1; RSTB = 1'b1;
        xfer(1'b1, 4'd1, 32'd0, q, ok);
        check("post_rst_ack", ok, 1);
        check("post_rst_div", q, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fll_clkdiv_bank.md
Name: fll_clkdiv_bank

Overview:
Synthesizable, parametrised successor to the behavioural FLL stand-in. It generates NB_FLL independent clocks from REFCLK, each by an integer divide of 2*D. Divide ratios are programmed through the FLL CFG request/acknowledge interface, and each channel reports a lock flag. It sits in the host clock tree wherever a real FLL macro is absent, including FPGA targets and RTL simulation.

Parameters:
- NB_FLL, 4, number of output clock channels (1..8).
- CFG_ADDR_WIDTH, 4, CFG address width; NB_FLL+1 <= 2**CFG_ADDR_WIDTH.
- CFG_DATA_WIDTH, 32, CFG data width; must be >= DIV_WIDTH.
- DIV_WIDTH, 8, width of each channel's divide field D.
- DIV_RESET, 1, D value loaded into every channel at reset.
- LOCK_CYCLES, 16, REFCLK cycles from applying a nonzero D until LOCK asserts (>= 1).

Ports:
- REFCLK  in  1  reference clock; all logic is on its rising edge.
- RSTB  in  1  asynchronous active-low reset.
- OUTCLK  out  NB_FLL  divided clocks, driven from registers.
- LOCK  out  NB_FLL  per-channel lock flag.
- CFGREQ  in  1  config request, active high, 4-phase.
- CFGACK  out  1  config acknowledge, one-cycle pulse.
- CFGAD  in  CFG_ADDR_WIDTH  register address.
- CFGD  in  CFG_DATA_WIDTH  write data.
- CFGQ  out  CFG_DATA_WIDTH  read data, valid while CFGACK=1.
- CFGWEB  in  1  write enable, active low.
- PWD  in  1  power down, active high, sampled synchronously.

Behaviour:
- Interface decision: one clock (REFCLK); reset is asynchronous and active-low (RSTB).
- Reset values:
  - OUTCLK=0, LOCK=0, CFGACK=0, CFGQ=0.
  - Active and shadow D = DIV_RESET for every channel; all counters = 0.
  - CFG FSM state = IDLE.
- Register map:
  - Address i < NB_FLL: data[DIV_WIDTH-1:0] = D for channel i; read returns the shadow D, zero-extended.
  - Address NB_FLL: status register (see Optional Feature).
  - Any other address: reads 0; writes are ignored.
- CFG FSM:
  - IDLE: on CFGREQ=1, capture CFGAD/CFGD/CFGWEB and go to ACK.
  - ACK: CFGACK=1 for exactly one cycle. For reads, CFGQ holds the read data in this cycle; otherwise CFGQ=0. For writes, the shadow D updates at the end of this cycle. Then go to WAITLO.
  - WAITLO: CFGACK=0; stay until CFGREQ=0, then return to IDLE.
  - Latency: REQ sampled at edge k gives CFGACK high between edges k+1 and k+2.
  - A request held high through WAITLO is not re-served.
- Divider, per channel, with active divide value A:
  - A=0: OUTCLK=0 and the counter is held at 0.
  - A>=1: the counter runs 0..A-1; at A-1 it wraps to 0 and OUTCLK toggles. Output frequency is REFCLK/(2A) with exactly 50% duty.
  - A = 2**DIV_WIDTH-1 must wrap correctly.
- Ratio update:
  - The shadow is copied to A only at a period boundary: the edge where OUTCLK toggles 1->0, or at once if A=0 or PWD=1.
  - The new ratio starts from counter 0 with OUTCLK low, so no runt pulse is produced.
  - A write equal to the current shadow has no effect on LOCK.
- Lock:
  - A write with a new shadow value different from A clears LOCK[i] in the ACK cycle.
  - When a nonzero D is applied, the lock counter restarts. LOCK[i] rises LOCK_CYCLES cycles after the apply edge.
  - Applying D=0 keeps LOCK[i]=0.
  - A second write before lock restarts the sequence.
- PWD=1:
  - Next edge: all OUTCLK=0, LOCK=0, counters=0; pending shadows are applied.
  - CFG access remains functional and registers are retained.
  - On PWD falling, channels restart from the low phase.
- Reset mid-operation: RSTB low forces all reset values asynchronously, including an in-flight ACK.
- Simultaneous events: a write landing on the same edge as a period boundary applies the new value immediately. A write during PWD is applied on PWD release.

Optional Feature:
- Macro: FLL_STATUS_REG_EN.
- Defined: address NB_FLL reads {zero-extend, LOCK[NB_FLL-1:0]}. A write to it with data bit0=1 forces every channel to apply its shadow at the next edge and restart lock (soft resync).
- Undefined: address NB_FLL behaves as unmapped: reads 0, writes ignored, no extra logic.

Test Plan:
- Reset release, DIV_RESET=1 -> every OUTCLK toggles every REFCLK cycle (REFCLK/2); LOCK=4'hF exactly 16 cycles after reset release.
- Write ch2 D=3 (CFGAD=2, CFGWEB=0) -> CFGACK is a one-cycle pulse at edge k+1; LOCK[2] drops; after the next 1->0 boundary, OUTCLK[2] runs 3 high / 3 low; LOCK[2] rises 16 cycles after apply.
- Read ch2 after that write -> CFGQ=32'h3 only during CFGACK; CFGQ=0 otherwise. Hold CFGREQ high for 10 cycles -> exactly one ACK.
- Write D=0 to ch0, then D=255 -> OUTCLK[0] goes low and stays low, LOCK[0]=0; then 255 high / 255 low with no runt pulse at the switch.
- PWD=1 for 20 cycles with a write of ch1 D=5 during it -> all OUTCLK=0 and LOCK=0; after release, ch1 runs at D=5 starting from the low phase.
- With FLL_STATUS_REG_EN: read address 4 -> 32'hF once locked; without it -> 0. Assert RSTB mid-ACK -> CFGACK=0 immediately.
